// File: rtl/reg_file.sv
// Per-thread register file: sixteen DATA_BITS-wide registers with
// thirteen general-purpose slots and three read-only thread-context
// registers (blockIdx, blockDim, threadIdx). Operands are read in
// REQUEST and written back in UPDATE.
module reg_file #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LSU  = 2'b01,
    SRC_IMM  = 2'b10,
    SRC_NONE = 2'b11
  } reg_src_t;

  // Highest register index that software is allowed to overwrite.
  localparam logic [3:0] LAST_GP_REG = 4'd12;

  localparam logic [DATA_BITS-1:0] BLOCK_DIM_RESET  = DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] THREAD_IDX_RESET = DATA_BITS'(THREAD_ID);

  logic [DATA_BITS-1:0] registers [16];
  logic [DATA_BITS-1:0] write_data;
  logic                 write_valid;

  // Select the writeback source and decide whether this cycle commits a write.
  always_comb begin
    write_data  = '0;
    write_valid = 1'b0;
    case (reg_src_t'(decoded_reg_input_mux))
      SRC_ALU:  write_data = alu_out;
      SRC_LSU:  write_data = lsu_out;
      SRC_IMM:  write_data = decoded_immediate;
      default:  write_data = '0;
    endcase
    write_valid = (core_state_t'(core_state) == CORE_UPDATE)
               && decoded_reg_write_enable
               && (decoded_rd_address <= LAST_GP_REG)
               && (reg_src_t'(decoded_reg_input_mux) != SRC_NONE);
  end

  // Register array, blockIdx mirror and operand outputs; reset beats enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 14; i++) begin
        registers[i] <= '0;
      end
      registers[14] <= BLOCK_DIM_RESET;
      registers[15] <= THREAD_IDX_RESET;
      rs            <= '0;
      rt            <= '0;
    end else if (enable) begin
      registers[13] <= DATA_BITS'(block_id);
      if (core_state_t'(core_state) == CORE_REQUEST) begin
        rs <= registers[decoded_rs_address];
        rt <= registers[decoded_rt_address];
      end
      if (write_valid) begin
        registers[decoded_rd_address] <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file with a queue-based scoreboard: each
// REQUEST pushes its hand-computed operands, and a monitor pops and
// compares them on the falling edge after the REQUEST edge.
module tb_reg_file;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_UPDATE  = 3'b110;

  localparam logic [1:0] M_ALU  = 2'b00;
  localparam logic [1:0] M_LSU  = 2'b01;
  localparam logic [1:0] M_IMM  = 2'b10;
  localparam logic [1:0] M_NONE = 2'b11;

  typedef struct {
    string      name;
    logic [7:0] rs;
    logic [7:0] rt;
  } expect_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] blockId;
  logic [2:0] coreState;
  logic [3:0] rdAddr;
  logic [3:0] rsAddr;
  logic [3:0] rtAddr;
  logic       regWe;
  logic [1:0] regMux;
  logic [7:0] immediate;
  logic [7:0] aluOut;
  logic [7:0] lsuOut;
  logic [7:0] rs;
  logic [7:0] rt;

  logic       nextReset   = 1'b0;
  logic       nextEnable  = 1'b1;
  logic [7:0] nextBlockId = 8'd0;

  expect_t    expQ [$];
  logic       reqSeen   = 1'b0;
  logic       stimDone  = 1'b0;
  int         compared  = 0;
  int         mismatched = 0;

  reg_file #(
    .THREADS_PER_BLOCK(4),
    .THREAD_ID(2),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .block_id(blockId),
    .core_state(coreState),
    .decoded_rd_address(rdAddr),
    .decoded_rs_address(rsAddr),
    .decoded_rt_address(rtAddr),
    .decoded_reg_write_enable(regWe),
    .decoded_reg_input_mux(regMux),
    .decoded_immediate(immediate),
    .alu_out(aluOut),
    .lsu_out(lsuOut),
    .rs(rs),
    .rt(rt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and wait for the capturing rising edge.
  task automatic applyStimulus(input logic [2:0] state, input logic [3:0] rd,
                               input logic [3:0] rsA, input logic [3:0] rtA,
                               input logic we, input logic [1:0] mux,
                               input logic [7:0] imm, input logic [7:0] alu,
                               input logic [7:0] lsu);
    @(negedge clk);
    reset     = nextReset;
    enable    = nextEnable;
    blockId   = nextBlockId;
    coreState = state;
    rdAddr    = rd;
    rsAddr    = rsA;
    rtAddr    = rtA;
    regWe     = we;
    regMux    = mux;
    immediate = imm;
    aluOut    = alu;
    lsuOut    = lsu;
    @(posedge clk);
  endtask

  // Issue a REQUEST and record what the operands must read afterwards.
  task automatic request(input string name, input logic [3:0] rsA, input logic [3:0] rtA,
                         input logic [7:0] expRs, input logic [7:0] expRt);
    expect_t e;
    e.name = name;
    e.rs   = expRs;
    e.rt   = expRt;
    expQ.push_back(e);
    applyStimulus(S_REQUEST, 4'd0, rsA, rtA, 1'b0, M_NONE, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic update(input logic [3:0] rd, input logic we, input logic [1:0] mux,
                        input logic [7:0] imm, input logic [7:0] alu, input logic [7:0] lsu);
    applyStimulus(S_UPDATE, rd, 4'd0, 4'd0, we, mux, imm, alu, lsu);
  endtask

  task automatic idle();
    applyStimulus(S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, M_NONE, 8'h00, 8'h00, 8'h00);
  endtask

  // Compare the operand outputs against one scoreboard entry.
  task automatic checkOutput(input expect_t e);
    compared++;
    if (rs !== e.rs || rt !== e.rt) begin
      mismatched++;
      $display("[TB] FAIL %s: got rs=%02h rt=%02h, expected rs=%02h rt=%02h",
               e.name, rs, rt, e.rs, e.rt);
    end
  endtask

  // Note every rising edge that presented a REQUEST, so its result is checked next falling edge.
  always @(posedge clk) begin
    reqSeen <= (coreState == S_REQUEST);
  end

  // Monitor: pop and compare after each REQUEST edge, then drain and summarise.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (reqSeen) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_request: got rs=%02h rt=%02h, expected no response",
                   rs, rt);
        end else begin
          e = expQ.pop_front();
          checkOutput(e);
        end
      end
      if (stimDone) begin
        while (expQ.size() != 0) begin
          e = expQ.pop_front();
          compared++;
          mismatched++;
          $display("[TB] FAIL %s: got no response, expected rs=%02h rt=%02h",
                   e.name, e.rs, e.rt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    reset = 1'b0; enable = 1'b1; blockId = 8'd0; coreState = S_IDLE;
    rdAddr = '0; rsAddr = '0; rtAddr = '0; regWe = 1'b0; regMux = M_NONE;
    immediate = '0; aluOut = '0; lsuOut = '0;

    nextReset = 1'b0;
    idle();
    idle();
    nextReset = 1'b1;

    request("reset_ctx_regs", 4'd14, 4'd15, 8'h04, 8'h02);
    request("reset_gp_regs", 4'd0, 4'd12, 8'h00, 8'h00);

    update(4'd3, 1'b1, M_ALU, 8'h00, 8'h5A, 8'h00);
    request("alu_writeback", 4'd3, 4'd0, 8'h5A, 8'h00);

    update(4'd1, 1'b1, M_LSU, 8'h00, 8'h00, 8'h11);
    update(4'd2, 1'b1, M_IMM, 8'hF0, 8'h00, 8'h00);
    update(4'd1, 1'b1, M_NONE, 8'h00, 8'h77, 8'h00);
    request("lsu_imm_none_sources", 4'd1, 4'd2, 8'h11, 8'hF0);

    update(4'd15, 1'b1, M_IMM, 8'h99, 8'h00, 8'h00);
    update(4'd14, 1'b1, M_IMM, 8'h99, 8'h00, 8'h00);
    request("readonly_r15_r14", 4'd15, 4'd14, 8'h02, 8'h04);

    update(4'd3, 1'b0, M_IMM, 8'hEE, 8'h00, 8'h00);
    request("we_low_same_addr", 4'd3, 4'd3, 8'h5A, 8'h5A);

    update(4'd12, 1'b1, M_IMM, 8'hC3, 8'h00, 8'h00);
    request("write_r12_boundary", 4'd12, 4'd13, 8'hC3, 8'h00);

    applyStimulus(S_EXECUTE, 4'd4, 4'd0, 4'd0, 1'b1, M_IMM, 8'hAB, 8'h00, 8'h00);
    request("non_update_write", 4'd4, 4'd4, 8'h00, 8'h00);

    nextBlockId = 8'd7;
    idle();
    request("r13_tracking", 4'd13, 4'd0, 8'h07, 8'h00);

    nextEnable  = 1'b0;
    nextBlockId = 8'd9;
    update(4'd4, 1'b1, M_IMM, 8'h33, 8'h00, 8'h00);
    request("disabled_hold", 4'd0, 4'd1, 8'h07, 8'h00);
    nextEnable = 1'b1;
    request("disabled_no_write", 4'd4, 4'd13, 8'h00, 8'h07);

    update(4'd5, 1'b1, M_IMM, 8'h44, 8'h00, 8'h00);
    request("pre_reset_write", 4'd5, 4'd5, 8'h44, 8'h44);
    nextReset = 1'b0;
    update(4'd6, 1'b1, M_IMM, 8'h55, 8'h00, 8'h00);
    nextReset = 1'b1;
    idle();
    request("mid_instr_reset", 4'd5, 4'd6, 8'h00, 8'h00);
    request("post_reset_ctx", 4'd15, 4'd13, 8'h02, 8'h09);

    idle();
    idle();
    stimDone = 1'b1;
  end

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Per-thread register file for each core: one instance per thread slot, alongside that thread's ALU and LSU.
- Supplies the `rs`/`rt` operands the ALU consumes during EXECUTE.
- Writes back the ALU result, LSU load data or decoded immediate during UPDATE.
- Hosts read-only thread-context registers for blockIdx, blockDim and threadIdx.

Parameters:
- THREADS_PER_BLOCK, 4, block size; reset/constant value of R14 (blockDim).
- THREAD_ID, 0, this instance's thread index; reset/constant value of R15 (threadIdx).
- DATA_BITS, 8, register/data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset. reset==0 at a rising edge resets; reset==1 is normal operation.
- enable  in  1  thread active in current block; 0 = instance frozen.
- block_id  in  8  current block index, mirrored into R13.
- core_state  in  3  core FSM state: 000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE.
- decoded_rd_address  in  4  destination register.
- decoded_rs_address  in  4  source register 1.
- decoded_rt_address  in  4  source register 2.
- decoded_reg_write_enable  in  1  instruction writes rd.
- decoded_reg_input_mux  in  2  write source: 00 ALU, 01 LSU, 10 IMMEDIATE, 11 none.
- decoded_immediate  in  8  constant for IMMEDIATE writes.
- alu_out  in  8  ALU result.
- lsu_out  in  8  LSU load data.
- rs  out  8  registered operand 1.
- rt  out  8  registered operand 2.

Behaviour:
- Storage: 16 x DATA_BITS registers.
  - R0-R12 general purpose.
  - R13 = blockIdx, R14 = blockDim, R15 = threadIdx; all three read-only.
- Reset (reset==0 at posedge) overrides everything, including enable:
  - R0-R13 <= 0; R14 <= THREADS_PER_BLOCK; R15 <= THREAD_ID.
  - rs <= 0; rt <= 0.
  - Mid-instruction reset discards any pending write.
- enable==0: no register, rs, rt or R13 change; outputs hold last value.
- R13 tracking: when enabled and not in reset, R13 <= block_id every cycle, regardless of core_state.
  - Visible to a REQUEST read one cycle after block_id changes.
- REQUEST (011), enabled:
  - rs <= reg[decoded_rs_address]; rt <= reg[decoded_rt_address].
  - Latency 1 cycle; values stable from the next cycle until the next REQUEST.
  - rs_address == rt_address is legal; both outputs get the same value.
- UPDATE (110), enabled, decoded_reg_write_enable==1, decoded_rd_address <= 12:
  - reg[rd] <= mux-selected source, sampled that same edge: 00 alu_out, 01 lsu_out, 10 decoded_immediate.
  - mux 11: no write.
- Silently ignored writes: rd in 13..15, write_enable==0, or any state other than UPDATE.
- Hazards: no same-cycle read/write (REQUEST and UPDATE are distinct states). A write in UPDATE is visible to the next instruction's REQUEST.
- Inputs are not registered; only rs/rt and the register array are sequential.
- No X on outputs after the first reset edge.

Test Plan:
- Reset: hold reset=0 two cycles, THREADS_PER_BLOCK=4, THREAD_ID=2. REQUEST rs=14, rt=15 -> rs=4, rt=2; REQUEST rs=0, rt=12 -> 0, 0.
- ALU writeback: UPDATE, rd=3, mux=00, alu_out=0x5A, we=1. Next REQUEST rs=3 -> rs=0x5A one cycle after REQUEST.
- Sources: write R1=lsu_out 0x11 (mux 01), R2=imm 0xF0 (mux 10). Then mux 11 with rd=1, alu_out=0x77 -> R1 stays 0x11. REQUEST rs=1, rt=2 -> 0x11, 0xF0.
- Read-only protection: UPDATE rd=15, imm 0x99, we=1 -> R15 unchanged (THREAD_ID). Same for rd=14.
- R13 tracking: block_id=7, then REQUEST rs=13 -> rs=7.
- Gating: enable=0 across UPDATE rd=4, imm 0x33 and a REQUEST -> rs/rt hold, R4 stays 0.
- Reset mid-instruction: write R5=0x44; assert reset=0 in the UPDATE cycle of a write R6=0x55 -> after release both R5 and R6 read 0.
